apb_controller: RTL and testbench
=================================

Name: apb_controller

Overview:
- APB-side initiator of the AHB2APB bridge.
- Consumes the AHB slave front-end's qualified transfer (valid, hwrite, hwrite_reg) and its pipelined addresses (haddr, haddr1, haddr2).
- Sequences APB SETUP/ENABLE phases, drives psel/penable/paddr/pwdata/pwrite, and stalls AHB via hready_out.
- Supports single reads, single writes and back-to-back pipelined writes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NSLV, 3, number of one-hot APB selects

Ports:
hclk  input  1  bridge clock
hresetn  input  1  synchronous active-low reset
valid  input  1  qualified AHB transfer in address phase
hwrite  input  1  write flag of current address phase
hwrite_reg  input  1  hwrite delayed one cycle
haddr  input  ADDR_W  current AHB address
haddr1  input  ADDR_W  haddr delayed 1 cycle
haddr2  input  ADDR_W  haddr delayed 2 cycles
hwdata  input  DATA_W  AHB write data (data phase)
pready  input  1  APB ready (only with APB_WAIT_EN)
pwrite  output  1  APB direction
penable  output  1  APB enable
pselx  output  NSLV  one-hot APB select
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
hready_out  output  1  AHB ready back to master

Behaviour:
- One clock (hclk). Reset is synchronous, active-low (hresetn). All outputs registered.
- Reset: state=IDLE, pwrite=0, penable=0, pselx=0, paddr=0, pwdata=0, hready_out=1.
- Outputs are computed from next state and registered, so they appear in the cycle the state is entered.
- States: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP.
- Transitions:
  - IDLE: valid&~hwrite->READ; valid&hwrite->WWAIT; else IDLE.
  - WWAIT: valid->WRITEP; else WRITE. Write data is now on hwdata.
  - READ->RENABLE.
  - WRITE: valid->WENABLEP; else WENABLE.
  - WRITEP->WENABLEP.
  - RENABLE, WENABLE: same as IDLE.
  - WENABLEP: ~hwrite_reg->READ; hwrite_reg&valid->WRITEP; hwrite_reg&~valid->WRITE.
- Address source on entering a SETUP state:
  - READ from IDLE/RENABLE/WENABLE: haddr.
  - READ from WENABLEP: haddr2.
  - WRITE/WRITEP from WWAIT: haddr1.
  - WRITE/WRITEP from WENABLEP: haddr2.
- pwdata is loaded from hwdata on entering WRITE or WRITEP. It holds otherwise.
- pselx is decoded from the selected paddr with pkg function sel_decode:
  - 0x8000_0000..0x83FF_FFFF -> 001
  - 0x8400_0000..0x87FF_FFFF -> 010
  - 0x8800_0000..0x8BFF_FFFF -> 100
  - else 000
- pselx holds through the ENABLE phase and is 0 in IDLE and WWAIT.
- penable=1 only in RENABLE, WENABLE and WENABLEP.
- pwrite=1 in WRITE, WRITEP, WENABLE and WENABLEP. pwrite=0 elsewhere.
- hready_out=0 in READ, WRITE and WRITEP; 1 in all other states.
- Each APB transfer is exactly 2 cycles (SETUP, ENABLE); no APB wait states unless APB_WAIT_EN is defined.
- Read latency: valid read at cycle N -> SETUP at N+1, ENABLE at N+2. prdata is returned combinationally by the front-end.
- Reset mid-transfer: next edge with hresetn=0 forces IDLE and reset values; in-flight APB transfer is abandoned.
- Addresses outside the map still run the APB sequence with pselx=000 (no error response).

Optional Feature:
- Macro: APB_WAIT_EN.
- Defined: the pready port exists. In RENABLE, WENABLE and WENABLEP, pready=0 holds state, penable, pselx, paddr and pwdata, and forces hready_out=0. Exit occurs on the cycle pready=1, per the normal transitions.
- Undefined: the pready port is absent and ENABLE lasts exactly 1 cycle.

Decomposition:
- bridge_pkg:
  - apb_state_t enum (8 states)
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - SLV0/1/2 base and limit constants
  - sel_decode function
- No sub-module; the FSM and output registers are a single module.

Test Plan:
- Reset: hresetn=0 for 2 cycles -> pselx=0, penable=0, paddr=0, hready_out=1.
- Single read:
  - Stimulus: valid=1, hwrite=0, haddr=0x8000_0010.
  - Next cycle: pselx=001, paddr=0x8000_0010, penable=0, hready_out=0.
  - Following cycle: penable=1, hready_out=1.
- Single write:
  - Stimulus: valid, hwrite, haddr=0x8400_0004, then hwdata=0xDEAD_BEEF.
  - Response: WWAIT, then WRITE with pselx=010, paddr=0x8400_0004, pwdata=0xDEAD_BEEF, pwrite=1, then WENABLE.
- Back-to-back writes:
  - Stimulus: writes to 0x8800_0000 and 0x8800_0004.
  - Response: WRITEP then WENABLEP, then WRITE with paddr=haddr2=0x8800_0004, pselx=100.
- Write followed by read:
  - Stimulus: WENABLEP reached with hwrite_reg=0.
  - Response: READ using haddr2, pwrite=0.
- Reset during WENABLE -> IDLE on the next edge, all outputs at reset values.
- APB_WAIT_EN: pready=0 for 3 cycles in RENABLE -> penable, paddr and pselx stable, hready_out=0; exit on the first pready=1.

Source files
------------

// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the AHB2APB bridge:
//   - apb_state_t   : APB-side sequencer states
//   - HTRANS_*      : AHB transfer-type encodings used by the slave front-end
//   - SLVn_BASE/LIMIT : APB peripheral address windows
//   - sel_decode()  : address -> one-hot APB select
// -----------------------------------------------------------------------------
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } apb_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  // Unmapped addresses give an all-zero select; the APB sequence still runs.
  function automatic logic [2:0] sel_decode(input logic [31:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= SLV0_BASE && addr <= SLV0_LIMIT)      sel = 3'b001;
    else if (addr >= SLV1_BASE && addr <= SLV1_LIMIT) sel = 3'b010;
    else if (addr >= SLV2_BASE && addr <= SLV2_LIMIT) sel = 3'b100;
    return sel;
  endfunction

endpackage

// File: rtl/apb_controller.sv
// -----------------------------------------------------------------------------
// apb_controller
// APB-side initiator of the AHB2APB bridge. Takes the qualified AHB transfer
// from the slave front-end and runs APB SETUP/ENABLE phases, stalling the AHB
// master through hready_out. Handles single reads, single writes and
// back-to-back pipelined writes. Every output is a register loaded from the
// next-state decode, so outputs change in the cycle a state is entered.
//
// Ports:
//   hclk, hresetn            clock, synchronous active-low reset
//   valid, hwrite, hwrite_reg qualified transfer, its direction, direction -1 cycle
//   haddr, haddr1, haddr2    AHB address now, -1 cycle, -2 cycles
//   hwdata                   AHB write data (data phase)
//   pready                   APB ready (present only with APB_WAIT_EN)
//   pwrite, penable, pselx, paddr, pwdata   APB request
//   hready_out               ready back to the AHB master
//
// Build option: define APB_WAIT_EN to add pready and allow APB wait states;
// otherwise every ENABLE phase lasts exactly one cycle.
// -----------------------------------------------------------------------------
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
`ifdef APB_WAIT_EN
  input  logic              pready,
`endif
  output logic              pwrite,
  output logic              penable,
  output logic [NSLV-1:0]   pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out
);

  apb_state_t        state_q, state_d;
  logic              pwrite_q, pwrite_d;
  logic              penable_q, penable_d;
  logic [NSLV-1:0]   pselx_q, pselx_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              hready_out_q, hready_out_d;

  logic              enable_hold;   // peripheral is extending the ENABLE phase
  logic [ADDR_W-1:0] setup_addr;    // address captured when a SETUP state is entered

`ifdef APB_WAIT_EN
  assign enable_hold = ~pready;
`else
  assign enable_hold = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (state_q != ST_IDLE && enable_hold) state_d = state_q;
        else if (valid)                        state_d = hwrite ? ST_WWAIT : ST_READ;
        else                                   state_d = ST_IDLE;
      end
      // Write data of the accepted write is on hwdata now.
      ST_WWAIT:  state_d = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:   state_d = ST_RENABLE;
      ST_WRITE:  state_d = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP: state_d = ST_WENABLEP;
      // A transfer is already queued behind this write; its direction and
      // address are two pipeline stages back.
      ST_WENABLEP: begin
        if (enable_hold)     state_d = ST_WENABLEP;
        else if (!hwrite_reg) state_d = ST_READ;
        else                 state_d = valid ? ST_WRITEP : ST_WRITE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode from the state being entered.
  always_comb begin
    if (state_q == ST_WENABLEP)  setup_addr = haddr2;
    else if (state_d == ST_READ) setup_addr = haddr;
    else                         setup_addr = haddr1;

    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pselx_d      = '0;
    penable_d    = 1'b0;
    pwrite_d     = 1'b0;
    hready_out_d = 1'b1;

    case (state_d)
      ST_READ: begin
        paddr_d      = setup_addr;
        pselx_d      = NSLV'(sel_decode(32'(setup_addr)));
        hready_out_d = 1'b0;
      end
      ST_WRITE, ST_WRITEP: begin
        paddr_d      = setup_addr;
        pwdata_d     = hwdata;
        pselx_d      = NSLV'(sel_decode(32'(setup_addr)));
        pwrite_d     = 1'b1;
        hready_out_d = 1'b0;
      end
      ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
        pselx_d      = pselx_q;
        penable_d    = 1'b1;
        pwrite_d     = (state_d != ST_RENABLE);
        // Staying in an ENABLE state only happens while the peripheral stalls.
        hready_out_d = ~(enable_hold && state_d == state_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // uses non-blocking assignments so every flop sees pre-edge values.
    if (!hresetn) begin
      state_q      <= ST_IDLE;
      pwrite_q     <= 1'b0;
      penable_q    <= 1'b0;
      pselx_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      hready_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pwrite_q     <= pwrite_d;
      penable_q    <= penable_d;
      pselx_q      <= pselx_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      hready_out_q <= hready_out_d;
    end
  end

  assign pwrite     = pwrite_q;
  assign penable    = penable_q;
  assign pselx      = pselx_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign hready_out = hready_out_q;

endmodule

// File: tb/tb_apb_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_controller
// Directed scenarios followed by randomized cycles. Expected outputs come from
// a transfer-level model: the bridge is either resting, waiting for write
// data, in an APB SETUP phase or in an APB ACCESS phase, and a write may carry
// a queued follow-on transfer. Select decode is computed arithmetically from
// the 64 MB peripheral windows.
// -----------------------------------------------------------------------------
module tb_apb_controller;

  logic        hclk;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic        hwrite_reg;
  logic [31:0] haddr, haddr1, haddr2;
  logic [31:0] hwdata;
  logic        pready;
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hready_out;

  int checks = 0;
  int errors = 0;

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .valid      (valid),
    .hwrite     (hwrite),
    .hwrite_reg (hwrite_reg),
    .haddr      (haddr),
    .haddr1     (haddr1),
    .haddr2     (haddr2),
    .hwdata     (hwdata),
`ifdef APB_WAIT_EN
    .pready     (pready),
`endif
    .pwrite     (pwrite),
    .penable    (penable),
    .pselx      (pselx),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .hready_out (hready_out)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- reference model ----------------
  typedef enum int {M_REST, M_WAIT, M_SETUP, M_ACCESS} m_kind_t;
  m_kind_t     m_kind = M_REST;
  logic        m_wr   = 1'b0;   // current APB transfer is a write
  logic        m_pipe = 1'b0;   // another transfer is queued behind this write
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;

  function automatic logic [2:0] exp_decode(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
      return 3'(32'd1 << ((a - 32'h8000_0000) >> 26));
    return 3'b000;
  endfunction

  task automatic model_start(input logic wr, input logic [31:0] a, input logic pipe);
    m_kind = M_SETUP;
    m_wr   = wr;
    m_addr = a;
    m_pipe = pipe;
    if (wr) m_data = hwdata;
  endtask

  task automatic model_accept();
    if (valid && hwrite) m_kind = M_WAIT;
    else if (valid)      model_start(1'b0, haddr, 1'b0);
    else                 m_kind = M_REST;
  endtask

  task automatic model_step();
    if (!hresetn) begin
      m_kind = M_REST; m_wr = 1'b0; m_pipe = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      case (m_kind)
        M_REST:   model_accept();
        M_WAIT:   model_start(1'b1, haddr1, valid);
        M_SETUP:  begin
          if (m_wr) m_pipe = m_pipe | valid;
          m_kind = M_ACCESS;
        end
        M_ACCESS: begin
          if (!m_pipe)          model_accept();
          else if (!hwrite_reg) model_start(1'b0, haddr2, 1'b0);
          else                  model_start(1'b1, haddr2, valid);
        end
        default:  m_kind = M_REST;
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic active;
    active = (m_kind == M_SETUP) || (m_kind == M_ACCESS);
    check("pselx",      32'(pselx),      32'(active ? exp_decode(m_addr) : 3'b000));
    check("penable",    32'(penable),    32'(m_kind == M_ACCESS));
    check("pwrite",     32'(pwrite),     32'(active && m_wr));
    check("hready_out", 32'(hready_out), 32'(m_kind != M_SETUP));
    check("paddr",      paddr,           m_addr);
    check("pwdata",     pwdata,          m_data);
  endtask

  // One clock: inputs already set, model advances on the same edge, outputs
  // sampled 1 time unit later.
  task automatic tick();
    @(posedge hclk);
    model_step();
    #1;
    check_model();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [6];
    edges = '{32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
              32'h8BFF_FFFF, 32'h8C00_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000 | ($urandom & 32'h03FF_FFFC);
      1: return 32'h8400_0000 | ($urandom & 32'h03FF_FFFC);
      2: return 32'h8800_0000 | ($urandom & 32'h03FF_FFFC);
      3: return edges[$urandom_range(0, 5)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    hresetn = 1'b0; valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b0;
    haddr = '0; haddr1 = '0; haddr2 = '0; hwdata = '0; pready = 1'b1;

    // Reset held for two cycles.
    tick(); tick();
    check("rst_pselx", 32'(pselx), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_hready", 32'(hready_out), 32'd1);
    hresetn = 1'b1;

    // Single read.
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010;
    tick();
    check("rd_setup_sel", 32'(pselx), 32'd1);
    check("rd_setup_addr", paddr, 32'h8000_0010);
    check("rd_setup_pen", 32'(penable), 32'd0);
    check("rd_setup_rdy", 32'(hready_out), 32'd0);
    valid = 1'b0;
    tick();
    check("rd_enable_pen", 32'(penable), 32'd1);
    check("rd_enable_rdy", 32'(hready_out), 32'd1);
    tick();

    // Single write.
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004;
    tick();
    check("wr_wwait_sel", 32'(pselx), 32'd0);
    valid = 1'b0; hwrite = 1'b0; haddr1 = 32'h8400_0004; hwdata = 32'hDEAD_BEEF;
    tick();
    check("wr_setup_sel", 32'(pselx), 32'd2);
    check("wr_setup_addr", paddr, 32'h8400_0004);
    check("wr_setup_data", pwdata, 32'hDEAD_BEEF);
    check("wr_setup_pwrite", 32'(pwrite), 32'd1);
    tick();
    check("wr_enable_pen", 32'(penable), 32'd1);
    tick();

    // Back-to-back writes, then a read queued behind a pipelined write.
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
    tick();                                     // WWAIT
    haddr = 32'h8800_0004; haddr1 = 32'h8800_0000; hwdata = 32'h1111_0000;
    tick();                                     // WRITEP
    check("b2b_p_addr", paddr, 32'h8800_0000);
    check("b2b_p_rdy", 32'(hready_out), 32'd0);
    valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b1;
    haddr2 = 32'h8800_0004; hwdata = 32'h2222_0004;
    tick();                                     // WENABLEP
    check("b2b_enp_pen", 32'(penable), 32'd1);
    valid = 1'b1;
    tick();                                     // WRITEP with haddr2
    check("b2b_2nd_addr", paddr, 32'h8800_0004);
    check("b2b_2nd_sel", 32'(pselx), 32'd4);
    check("b2b_2nd_data", pwdata, 32'h2222_0004);
    valid = 1'b0;
    tick();                                     // WENABLEP
    hwrite_reg = 1'b0; haddr2 = 32'h8000_0020;
    tick();                                     // READ from haddr2
    check("wr_rd_addr", paddr, 32'h8000_0020);
    check("wr_rd_pwrite", 32'(pwrite), 32'd0);
    tick(); tick();

    // Reset while in WENABLE.
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0100;
    tick();
    valid = 1'b0; haddr1 = 32'h8400_0100; hwdata = 32'hCAFE_F00D;
    tick(); tick();
    check("pre_rst_pen", 32'(penable), 32'd1);
    hresetn = 1'b0; valid = 1'b1;
    tick();
    check("mid_rst_sel", 32'(pselx), 32'd0);
    check("mid_rst_pen", 32'(penable), 32'd0);
    check("mid_rst_addr", paddr, 32'd0);
    check("mid_rst_data", pwdata, 32'd0);
    check("mid_rst_rdy", 32'(hready_out), 32'd1);
    hresetn = 1'b1; valid = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      hresetn    = ($urandom_range(0, 99) != 0);
      valid      = ($urandom_range(0, 2) != 0);
      hwrite     = 1'($urandom_range(0, 1));
      hwrite_reg = 1'($urandom_range(0, 1));
      haddr      = rand_addr();
      haddr1     = rand_addr();
      haddr2     = rand_addr();
      hwdata     = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
